alu_arbiter: RTL and testbench

- Shares one 32-bit ALU datapath between two requesters: port 0 (execute stage) and port 1 (address-generation/branch unit).
- Round-robin arbitration, valid/ready handshake on each request port, one registered response channel tagged with requester ID.
- Sits between the decode/issue logic and the shared combinational ALU.
- Registers the ALU result and flags, which removes the ALU from the issue-to-writeback critical path.

---
 rtl/alu_arbiter_pkg.sv | 30 +++
 rtl/rr_arbiter2.sv | 83 ++++++++
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-port ALU arbiter: opcodes, response-slot states and defaults.
// Imported by alu_arbiter and rr_arbiter2.
package alu_arbiter_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CTRLW_DEF = 4;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_CBZ  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_ORR  = 4'b0100;
  localparam logic [3:0] OP_EOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1101;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef enum logic {
    REQ_EXEC = 1'b0,
    REQ_AGU  = 1'b1
  } req_id_e;

  function automatic logic [1:0] onehotGrant(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a registered priority pointer.
// With ALU_ARBITER_LOCK_EN defined, a locked grantee keeps ownership until it releases.
module rr_arbiter2
  import alu_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic [1:0] reqValid,
`ifdef ALU_ARBITER_LOCK_EN
  input  logic [1:0] reqLock,
`endif
  input  logic       slotFree,
  output logic [1:0] grant,
  output logic       grantIdx,
  output logic       handshake
);

  logic rrPtr_q, rrPtr_d;
  logic pick;

`ifdef ALU_ARBITER_LOCK_EN
  logic lockActive_q, lockActive_d;
  logic owner_q, owner_d;
`endif

  // A lone requester always wins; contention is settled by the pointer or by a lock owner.
  always_comb begin
    case (reqValid)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = rrPtr_q;
    endcase
`ifdef ALU_ARBITER_LOCK_EN
    if (lockActive_q && reqValid[owner_q]) begin
      pick = owner_q;
    end
`endif
  end

  assign grantIdx  = pick;
  assign grant     = (reqValid == 2'b00) ? 2'b00 : onehotGrant(pick);
  assign handshake = (|reqValid) && slotFree;

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (handshake) begin
      rrPtr_d = ~pick;
    end
  end

`ifdef ALU_ARBITER_LOCK_EN
  // Ownership ends on an unlocked handshake from the owner or when the owner goes idle.
  always_comb begin
    lockActive_d = lockActive_q;
    owner_d      = owner_q;
    if (handshake) begin
      lockActive_d = reqLock[pick];
      owner_d      = pick;
    end else if (lockActive_q && !reqValid[owner_q]) begin
      lockActive_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lockActive_q <= 1'b0;
      owner_q      <= 1'b0;
    end else begin
      lockActive_q <= lockActive_d;
      owner_q      <= owner_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rrPtr_q <= 1'b0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the execute stage (port 0) and the AGU/branch unit (port 1).
// Result, flags and requester ID are registered; ALU_ARBITER_LOCK_EN adds the reqLock port.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CTRLW = CTRLW_DEF
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [1:0]       reqValid,
  output logic [1:0]       reqReady,
`ifdef ALU_ARBITER_LOCK_EN
  input  logic [1:0]       reqLock,
`endif
  input  logic [CTRLW-1:0] reqControl0,
  input  logic [CTRLW-1:0] reqControl1,
  input  logic [WIDTH-1:0] reqData1_0,
  input  logic [WIDTH-1:0] reqData1_1,
  input  logic [WIDTH-1:0] reqData2_0,
  input  logic [WIDTH-1:0] reqData2_1,
  output logic             respValid,
  input  logic             respReady,
  output logic             respId,
  output logic [WIDTH-1:0] aluResult,
  output logic             overflow,
  output logic             zeroFlag
);

  logic [0:0]       state_q, state_d;
  logic             respId_q, respId_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [1:0]       grant;
  logic             grantIdx;
  logic             handshake;
  logic             slotFree;

  logic [CTRLW-1:0] selCtrl;
  logic [WIDTH-1:0] selA, selB;
  logic [WIDTH:0]   aluOut;

  // Bit WIDTH carries the add carry / subtract borrow; every other opcode leaves it clear.
  function automatic logic [WIDTH:0] aluEval(input logic [CTRLW-1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_ORR:  r = {1'b0, a | b};
      OP_EOR:  r = {1'b0, a ^ b};
      OP_NOR:  r = {1'b0, ~(a | b)};
      OP_NAND: r = {1'b0, ~(a & b)};
      OP_MOV:  r = {1'b0, b};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign slotFree = (state_q == ST_EMPTY) || respReady;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .resetN    (resetN),
    .reqValid  (reqValid),
`ifdef ALU_ARBITER_LOCK_EN
    .reqLock   (reqLock),
`endif
    .slotFree  (slotFree),
    .grant     (grant),
    .grantIdx  (grantIdx),
    .handshake (handshake)
  );

  // Held low while in reset so nothing upstream sees an accept that will be discarded.
  assign reqReady = grant & {2{slotFree & resetN}};

  always_comb begin
    selCtrl = grantIdx ? reqControl1 : reqControl0;
    selA    = grantIdx ? reqData1_1  : reqData1_0;
    selB    = grantIdx ? reqData2_1  : reqData2_0;
  end

  assign aluOut = aluEval(selCtrl, selA, selB);

  // A drained slot keeps its last data; only respValid drops.
  always_comb begin
    state_d  = state_q;
    respId_d = respId_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    if (handshake) begin
      state_d  = ST_FULL;
      respId_d = grantIdx;
      result_d = aluOut[WIDTH-1:0];
      ovf_d    = aluOut[WIDTH];
      if (selCtrl == OP_CBZ) begin
        zero_d = (selB == '0);
      end
    end else if (respReady) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ST_EMPTY;
      respId_q <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      respId_q <= respId_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign respValid = (state_q == ST_FULL);
  assign respId    = respId_q;
  assign aluResult = result_q;
  assign overflow  = ovf_q;
  assign zeroFlag  = zero_q;

  assert property (@(posedge clk) disable iff (!resetN) $onehot0(reqReady));

  assert property (@(posedge clk) disable iff (!resetN)
    (respValid && !respReady) |=> (respValid && $stable(aluResult) &&
                                   $stable(respId) && $stable(overflow)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a reference model queues expected responses at each
// accepted request and a monitor compares them; scenario tasks add directed checks.
module tb_alu_arbiter;

  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b1010;
  localparam logic [3:0] CBZ  = 4'b0111;
  localparam logic [3:0] AND_ = 4'b0110;
  localparam logic [3:0] MOV  = 4'b1101;
  localparam logic [3:0] UNDF = 4'b1111;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [1:0]  reqLock;
  logic [3:0]  reqControl0, reqControl1;
  logic [31:0] reqData1_0, reqData1_1, reqData2_0, reqData2_1;
  logic        respValid, respReady, respId, overflow, zeroFlag;
  logic [31:0] aluResult;

  exp_t        sb[$];
  int          nTests = 0;
  int          nFail  = 0;
  logic        mRr    = 1'b0;
  logic        mZero  = 1'b0;

  int          mG, monG;
  logic        mFree;
  logic [3:0]  mOp;
  logic [31:0] mA, mB;
  logic [32:0] mR;
  exp_t        mE, monE;
  logic [1:0]  monReady;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk         (clk),
    .resetN      (resetN),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
`ifdef ALU_ARBITER_LOCK_EN
    .reqLock     (reqLock),
`endif
    .reqControl0 (reqControl0),
    .reqControl1 (reqControl1),
    .reqData1_0  (reqData1_0),
    .reqData1_1  (reqData1_1),
    .reqData2_0  (reqData2_0),
    .reqData2_1  (reqData2_1),
    .respValid   (respValid),
    .respReady   (respReady),
    .respId      (respId),
    .aluResult   (aluResult),
    .overflow    (overflow),
    .zeroFlag    (zeroFlag)
  );

  function automatic int modelGrant(input logic [1:0] v, input logic rr);
    if (v == 2'b00) return -1;
    if (v == 2'b11) return rr ? 1 : 0;
    return v[1] ? 1 : 0;
  endfunction

  function automatic logic [32:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'b0010: return {1'b0, a} + {1'b0, b};
      4'b1010: return {1'b0, a} - {1'b0, b};
      4'b0110: return {1'b0, a & b};
      4'b0100: return {1'b0, a | b};
      4'b1001: return {1'b0, a ^ b};
      4'b0101: return {1'b0, ~(a | b)};
      4'b1100: return {1'b0, ~(a & b)};
      4'b1101: return {1'b0, b};
      default: return 33'h0;
    endcase
  endfunction

  // Reference model: drain then refill the single response slot on each clock.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sb.delete();
      mRr   = 1'b0;
      mZero = 1'b0;
    end else begin
      mFree = (sb.size() == 0) || respReady;
      mG    = modelGrant(reqValid, mRr);
      if (sb.size() != 0 && respReady) void'(sb.pop_front());
      if (mG >= 0 && mFree) begin
        mOp = (mG == 1) ? reqControl1 : reqControl0;
        mA  = (mG == 1) ? reqData1_1  : reqData1_0;
        mB  = (mG == 1) ? reqData2_1  : reqData2_0;
        mR  = refAlu(mOp, mA, mB);
        mE.id  = (mG == 1);
        mE.res = mR[31:0];
        mE.ovf = mR[32];
        sb.push_back(mE);
        if (mOp == CBZ) mZero = (mB == 32'h0);
        mRr = (mG == 0);
      end
    end
  end

  // Monitor: mid low-phase comparison of handshake and response outputs against the model.
  always @(negedge clk) begin
    #2;
    monG     = modelGrant(reqValid, mRr);
    monReady = 2'b00;
    if (resetN && monG >= 0 && (sb.size() == 0 || respReady))
      monReady = (monG == 1) ? 2'b10 : 2'b01;
    nTests++;
    if (reqReady !== monReady) begin
      nFail++;
      $display("[TB] FAIL sb_reqReady: got %b want %b @%0t", reqReady, monReady, $time);
    end
    nTests++;
    if (respValid !== (sb.size() != 0)) begin
      nFail++;
      $display("[TB] FAIL sb_respValid: got %b want %b @%0t", respValid, sb.size() != 0, $time);
    end
    nTests++;
    if (zeroFlag !== mZero) begin
      nFail++;
      $display("[TB] FAIL sb_zeroFlag: got %b want %b @%0t", zeroFlag, mZero, $time);
    end
    if (sb.size() != 0) begin
      monE = sb[0];
      nTests++;
      if (respId !== monE.id || aluResult !== monE.res || overflow !== monE.ovf) begin
        nFail++;
        $display("[TB] FAIL sb_resp: got id=%b res=%h ovf=%b want id=%b res=%h ovf=%b @%0t",
                 respId, aluResult, overflow, monE.id, monE.res, monE.ovf, $time);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] v,
                               input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic rdy);
    @(negedge clk);
    reqValid    = v;
    reqControl0 = c0;
    reqData1_0  = a0;
    reqData2_0  = b0;
    reqControl1 = c1;
    reqData1_1  = a1;
    reqData2_1  = b1;
    respReady   = rdy;
  endtask

  task automatic test_reset();
    resetN = 1'b0; reqLock = 2'b00; respReady = 1'b0;
    reqValid = 2'b01; reqControl0 = ADD; reqData1_0 = 32'd1; reqData2_0 = 32'd2;
    reqControl1 = MOV; reqData1_1 = 32'd0; reqData2_1 = 32'h5;
    #12;
    nTests++;
    if (reqReady !== 2'b00 || respValid !== 1'b0 || aluResult !== 32'h0 ||
        overflow !== 1'b0 || zeroFlag !== 1'b0 || respId !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_state: got rdy=%b v=%b res=%h ovf=%b z=%b id=%b want all 0",
               reqReady, respValid, aluResult, overflow, zeroFlag, respId);
    end
    @(negedge clk); reqValid = 2'b00; resetN = 1'b1;
    applyStimulus(2'b01, ADD, 32'd1, 32'd2, MOV, 32'd0, 32'h5, 1'b0);
    @(posedge clk); #1;
    nTests++;
    if (respValid !== 1'b1 || aluResult !== 32'd3) begin
      nFail++;
      $display("[TB] FAIL reset_preload: got v=%b res=%h want v=1 res=3", respValid, aluResult);
    end
    resetN = 1'b0; reqValid = 2'b11;
    #1;
    nTests++;
    if (respValid !== 1'b0 || aluResult !== 32'h0 || overflow !== 1'b0 ||
        respId !== 1'b0 || reqReady !== 2'b00) begin
      nFail++;
      $display("[TB] FAIL reset_async: got v=%b res=%h ovf=%b id=%b rdy=%b want 0",
               respValid, aluResult, overflow, respId, reqReady);
    end
    @(negedge clk); resetN = 1'b1;
    #1;
    nTests++;
    if (reqReady !== 2'b01) begin
      nFail++;
      $display("[TB] FAIL reset_rrptr: got rdy=%b want 01", reqReady);
    end
  endtask

  task automatic test_carry();
    applyStimulus(2'b01, ADD, 32'hFFFF_FFFF, 32'h1, MOV, 32'h0, 32'h0, 1'b1);
    applyStimulus(2'b00, ADD, 32'h0, 32'h0, MOV, 32'h0, 32'h0, 1'b1);
    #1;
    nTests++;
    if (respValid !== 1'b1 || respId !== 1'b0 || aluResult !== 32'h0 || overflow !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL carry: got v=%b id=%b res=%h ovf=%b want v=1 id=0 res=0 ovf=1",
               respValid, respId, aluResult, overflow);
    end
  endtask

  task automatic test_round_robin();
    logic        expId;
    logic [31:0] expRes;
    applyStimulus(2'b11, SUB, 32'd5, 32'd3, MOV, 32'h0, 32'hA5A5_A5A5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, SUB, 32'd5, 32'd3, MOV, 32'h0, 32'hA5A5_A5A5, 1'b1);
      #1;
      // Requester 0 won last, so requester 1 leads the alternation.
      expId  = (i % 2 == 0);
      expRes = expId ? 32'hA5A5_A5A5 : 32'd2;
      nTests++;
      if (respValid !== 1'b1 || respId !== expId || aluResult !== expRes || overflow !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL rr_%0d: got v=%b id=%b res=%h ovf=%b want v=1 id=%b res=%h ovf=0",
                 i, respValid, respId, aluResult, overflow, expId, expRes);
      end
    end
  endtask

  task automatic test_backpressure();
    applyStimulus(2'b01, ADD, 32'd10, 32'd20, MOV, 32'h0, 32'h1234, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b11, ADD, 32'd10, 32'd20, MOV, 32'h0, 32'h1234, 1'b0);
      #1;
      nTests++;
      if (reqReady !== 2'b00 || respValid !== 1'b1 || respId !== 1'b0 || aluResult !== 32'd30) begin
        nFail++;
        $display("[TB] FAIL stall_%0d: got rdy=%b v=%b id=%b res=%h want rdy=00 v=1 id=0 res=1e",
                 i, reqReady, respValid, respId, aluResult);
      end
    end
    applyStimulus(2'b10, ADD, 32'd10, 32'd20, MOV, 32'h0, 32'h1234, 1'b1);
    #1;
    nTests++;
    if (reqReady !== 2'b10 || aluResult !== 32'd30) begin
      nFail++;
      $display("[TB] FAIL drain_refill: got rdy=%b res=%h want rdy=10 res=1e", reqReady, aluResult);
    end
    applyStimulus(2'b00, ADD, 32'h0, 32'h0, MOV, 32'h0, 32'h0, 1'b1);
    #1;
    nTests++;
    if (respValid !== 1'b1 || respId !== 1'b1 || aluResult !== 32'h1234) begin
      nFail++;
      $display("[TB] FAIL refill_resp: got v=%b id=%b res=%h want v=1 id=1 res=1234",
               respValid, respId, aluResult);
    end
    applyStimulus(2'b00, ADD, 32'h0, 32'h0, MOV, 32'h0, 32'h0, 1'b1);
    #1;
    nTests++;
    if (respValid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL drain_empty: got v=%b want 0", respValid);
    end
  endtask

  task automatic test_sticky_zero();
    applyStimulus(2'b10, ADD, 32'h0, 32'h0, CBZ, 32'h9, 32'h0, 1'b1);
    applyStimulus(2'b01, AND_, 32'hF0, 32'h0F, MOV, 32'h0, 32'h0, 1'b1);
    #1;
    nTests++;
    if (zeroFlag !== 1'b1 || aluResult !== 32'h0 || overflow !== 1'b0 || respId !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL cbz_zero: got z=%b res=%h ovf=%b id=%b want z=1 res=0 ovf=0 id=1",
               zeroFlag, aluResult, overflow, respId);
    end
    applyStimulus(2'b10, ADD, 32'h0, 32'h0, CBZ, 32'h0, 32'h7, 1'b1);
    #1;
    nTests++;
    if (zeroFlag !== 1'b1 || aluResult !== 32'h0 || respId !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL and_keeps_zero: got z=%b res=%h id=%b want z=1 res=0 id=0",
               zeroFlag, aluResult, respId);
    end
    applyStimulus(2'b00, ADD, 32'h0, 32'h0, MOV, 32'h0, 32'h0, 1'b1);
    #1;
    nTests++;
    if (zeroFlag !== 1'b0 || aluResult !== 32'h0 || respId !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL cbz_nonzero: got z=%b res=%h id=%b want z=0 res=0 id=1",
               zeroFlag, aluResult, respId);
    end
  endtask

  task automatic test_borrow_undef();
    applyStimulus(2'b01, SUB, 32'h0, 32'h1, MOV, 32'h0, 32'h0, 1'b1);
    applyStimulus(2'b01, UNDF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MOV, 32'h0, 32'h0, 1'b1);
    #1;
    nTests++;
    if (aluResult !== 32'hFFFF_FFFF || overflow !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL borrow: got res=%h ovf=%b want res=ffffffff ovf=1", aluResult, overflow);
    end
    applyStimulus(2'b00, ADD, 32'h0, 32'h0, MOV, 32'h0, 32'h0, 1'b1);
    #1;
    nTests++;
    if (respValid !== 1'b1 || aluResult !== 32'h0 || overflow !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL undef_op: got v=%b res=%h ovf=%b want v=1 res=0 ovf=0",
               respValid, aluResult, overflow);
    end
    nTests++;
    if ($isunknown({respValid, respId, aluResult, overflow, zeroFlag, reqReady})) begin
      nFail++;
      $display("[TB] FAIL undef_noX: got res=%h ovf=%b z=%b id=%b want no X",
               aluResult, overflow, zeroFlag, respId);
    end
    applyStimulus(2'b00, ADD, 32'h0, 32'h0, MOV, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_sticky_zero();
    test_borrow_undef();
    repeat (2) @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
